// File: rtl/scs8hd_lpflow_isoseq.sv
// rtl/scs8hd_lpflow_isoseq.sv - sequenced multi-channel input-isolation controller
//
// Purpose: clamps NCH channels of W bits from a switchable power domain while
// isolation is applied. A registered isolate/release handshake with settle
// delays sits in front of the clamp, and losing pwrgood forces isolation at once.
// Optional feature macro: LPFLOW_ISO_HOLD_EN. When it is defined, isolated
// channels drive the last value captured before isolation instead of CLAMP_VAL.
//
// Ports:
//   clk        in   rising-edge clock
//   resetb     in   asynchronous active-low reset (powers up isolated)
//   a          in   NCH*W data from the switchable domain, channel i = a[i*W +: W]
//   x          out  NCH*W isolated data toward always-on logic
//   chan_mask  in   NCH per-channel exemption (1 = always pass-through)
//   sleep_req  in   isolation request from the power controller
//   pwrgood    in   switchable-domain supply valid
//   iso_active out  isolation applied to non-exempt channels
//   sleep_ack  out  isolation settled, domain may be powered down
//   pwr_fault  out  sticky: pwrgood fell while active

module scs8hd_lpflow_isoseq #(
  parameter int             NCH       = 4,
  parameter int             W         = 8,
  parameter logic [W-1:0]   CLAMP_VAL = '0,
  parameter int             ISO_DLY   = 2,
  parameter int             REL_DLY   = 3
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [NCH*W-1:0] a,
  output logic [NCH*W-1:0] x,
  input  logic [NCH-1:0]   chan_mask,
  input  logic             sleep_req,
  input  logic             pwrgood,
  output logic             iso_active,
  output logic             sleep_ack,
  output logic             pwr_fault
);

  localparam logic [1:0] ST_ACTIVE   = 2'd0;
  localparam logic [1:0] ST_ISO_WAIT = 2'd1;
  localparam logic [1:0] ST_ISOLATED = 2'd2;
  localparam logic [1:0] ST_REL_WAIT = 2'd3;

  localparam logic [3:0] ISO_CNT = ISO_DLY[3:0];
  localparam logic [3:0] REL_CNT = REL_DLY[3:0];

  // The settle counter is 4 bits wide, so longer delays cannot be honoured.
  if (ISO_DLY < 0 || ISO_DLY > 15) begin : g_bad_iso_dly
    $error("ISO_DLY must be in 0..15");
  end
  if (REL_DLY < 0 || REL_DLY > 15) begin : g_bad_rel_dly
    $error("REL_DLY must be in 0..15");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       iso_active_q, iso_active_d;
  logic       sleep_ack_q, sleep_ack_d;
  logic       pwr_fault_q, pwr_fault_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    iso_active_d = iso_active_q;
    sleep_ack_d  = sleep_ack_q;
    pwr_fault_d  = pwr_fault_q;
    case (state_q)
      ST_ACTIVE: begin
        // Supply loss wins over any pending sleep request.
        if (!pwrgood) begin
          state_d      = ST_ISOLATED;
          iso_active_d = 1'b1;
          sleep_ack_d  = 1'b1;
          pwr_fault_d  = 1'b1;
          cnt_d        = 4'd0;
        end else if (sleep_req) begin
          iso_active_d = 1'b1;
          if (ISO_DLY == 0) begin
            state_d     = ST_ISOLATED;
            sleep_ack_d = 1'b1;
          end else begin
            state_d = ST_ISO_WAIT;
            cnt_d   = ISO_CNT;
          end
        end
      end
      ST_ISO_WAIT: begin
        // Once started, isolation always completes regardless of sleep_req.
        if (cnt_q == 4'd1) begin
          state_d     = ST_ISOLATED;
          sleep_ack_d = 1'b1;
          cnt_d       = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ISOLATED: begin
        if (!sleep_req && pwrgood) begin
          sleep_ack_d = 1'b0;
          pwr_fault_d = 1'b0;
          if (REL_DLY == 0) begin
            state_d      = ST_ACTIVE;
            iso_active_d = 1'b0;
          end else begin
            state_d = ST_REL_WAIT;
            cnt_d   = REL_CNT;
          end
        end
      end
      default: begin
        // Release wait: iso_active stays high, so an abort only re-raises ack.
        if (sleep_req || !pwrgood) begin
          state_d     = ST_ISOLATED;
          sleep_ack_d = 1'b1;
          cnt_d       = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d      = ST_ACTIVE;
          iso_active_d = 1'b0;
          cnt_d        = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_ISOLATED;
      cnt_q        <= 4'd0;
      iso_active_q <= 1'b1;
      sleep_ack_q  <= 1'b1;
      pwr_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      iso_active_q <= iso_active_d;
      sleep_ack_q  <= sleep_ack_d;
      pwr_fault_q  <= pwr_fault_d;
    end
  end

  assign iso_active = iso_active_q;
  assign sleep_ack  = sleep_ack_q;
  assign pwr_fault  = pwr_fault_q;

  // Value presented on a clamped channel.
  logic [NCH*W-1:0] iso_val;

`ifdef LPFLOW_ISO_HOLD_EN
  logic [NCH*W-1:0] hold_q, hold_d;

  // Track live data while released, freeze once isolation is applied.
  always_comb begin
    hold_d = iso_active_q ? hold_q : a;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_q <= {NCH{CLAMP_VAL}};
    end else begin
      hold_q <= hold_d;
    end
  end

  assign iso_val = hold_q;
`else
  assign iso_val = {NCH{CLAMP_VAL}};
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign x[i*W +: W] = (iso_active_q && !chan_mask[i]) ? iso_val[i*W +: W] : a[i*W +: W];
  end

endmodule

// File: tb/tb_scs8hd_lpflow_isoseq.sv
// tb/tb_scs8hd_lpflow_isoseq.sv - randomized scoreboard bench for scs8hd_lpflow_isoseq

module tb_scs8hd_lpflow_isoseq;

  localparam int           NCH       = 4;
  localparam int           W         = 8;
  localparam logic [W-1:0] CLAMP_VAL = 8'h00;
  localparam int           ISO_DLY   = 2;
  localparam int           REL_DLY   = 3;
  localparam int           NCYC      = 3000;

  logic             clk;
  logic             resetb;
  logic [NCH*W-1:0] a;
  logic [NCH*W-1:0] x;
  logic [NCH-1:0]   chan_mask;
  logic             sleep_req;
  logic             pwrgood;
  logic             iso_active;
  logic             sleep_ack;
  logic             pwr_fault;

  scs8hd_lpflow_isoseq #(
    .NCH(NCH), .W(W), .CLAMP_VAL(CLAMP_VAL), .ISO_DLY(ISO_DLY), .REL_DLY(REL_DLY)
  ) dut (
    .clk(clk), .resetb(resetb), .a(a), .x(x), .chan_mask(chan_mask),
    .sleep_req(sleep_req), .pwrgood(pwrgood), .iso_active(iso_active),
    .sleep_ack(sleep_ack), .pwr_fault(pwr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH*W-1:0] x;
    logic             iso;
    logic             ack;
    logic             fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: timing expressed as absolute due-cycles rather than a counter.
  int           cyc     = 0;
  int           ack_due = -1;
  int           rel_due = -1;
  logic         m_iso, m_ack, m_fault;
  logic [W-1:0] m_hold [NCH];

  task automatic check1(input string name, input logic [NCH*W-1:0] got, input logic [NCH*W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_iso   = 1'b1;
    m_ack   = 1'b1;
    m_fault = 1'b0;
    ack_due = -1;
    rel_due = -1;
    for (int i = 0; i < NCH; i++) m_hold[i] = CLAMP_VAL;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    cyc++;
    if (!resetb) begin
      model_reset();
      return;
    end
`ifdef LPFLOW_ISO_HOLD_EN
    if (!m_iso) for (int i = 0; i < NCH; i++) m_hold[i] = a[i*W +: W];
`endif
    if (!m_iso) begin
      if (!pwrgood) begin
        m_iso = 1'b1; m_ack = 1'b1; m_fault = 1'b1;
      end else if (sleep_req) begin
        m_iso = 1'b1;
        if (ISO_DLY == 0) m_ack = 1'b1;
        else ack_due = cyc + ISO_DLY;
      end
    end else if (ack_due >= 0) begin
      if (cyc == ack_due) begin
        m_ack   = 1'b1;
        ack_due = -1;
      end
    end else if (rel_due >= 0) begin
      if (sleep_req || !pwrgood) begin
        m_ack   = 1'b1;
        rel_due = -1;
      end else if (cyc == rel_due) begin
        m_iso   = 1'b0;
        rel_due = -1;
      end
    end else if (!sleep_req && pwrgood) begin
      m_ack   = 1'b0;
      m_fault = 1'b0;
      if (REL_DLY == 0) m_iso = 1'b0;
      else rel_due = cyc + REL_DLY;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      e.x[i*W +: W] = a[i*W +: W];
      if (m_iso && !chan_mask[i]) begin
`ifdef LPFLOW_ISO_HOLD_EN
        e.x[i*W +: W] = m_hold[i];
`else
        e.x[i*W +: W] = CLAMP_VAL;
`endif
      end
    end
    e.iso   = m_iso;
    e.ack   = m_ack;
    e.fault = m_fault;
    return e;
  endfunction

  task automatic randomize_inputs(input int it);
    if (it < 12) begin
      a         = 32'hA5A5_5A5A;
      chan_mask = '0;
      sleep_req = 1'b0;
      pwrgood   = 1'b1;
    end else begin
      if ($urandom_range(0, 3) != 0) a = $urandom();
      if (it % 64 == 0) chan_mask = NCH'($urandom_range(0, (1 << NCH) - 1));
      if ($urandom_range(0, 7) == 0) sleep_req = ~sleep_req;
      if (pwrgood) pwrgood = ($urandom_range(0, 29) != 0);
      else         pwrgood = ($urandom_range(0, 2) == 0);
    end
  endtask

  // Monitor: every falling edge the DUT presents a settled output set.
  logic started = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty at t=%0t: got 0 entries expected 1", $time);
        end else begin
          e = exp_q.pop_front();
          check1("x",          x,                          e.x);
          check1("iso_active", {{(NCH*W-1){1'b0}}, iso_active}, {{(NCH*W-1){1'b0}}, e.iso});
          check1("sleep_ack",  {{(NCH*W-1){1'b0}}, sleep_ack},  {{(NCH*W-1){1'b0}}, e.ack});
          check1("pwr_fault",  {{(NCH*W-1){1'b0}}, pwr_fault},  {{(NCH*W-1){1'b0}}, e.fault});
        end
      end
    end
  end

  // Stimulus: drive inputs just after each rising edge and post the expected outputs.
  initial begin
    resetb    = 1'b0;
    a         = 32'hA5A5_5A5A;
    chan_mask = '0;
    sleep_req = 1'b0;
    pwrgood   = 1'b1;
    model_reset();
    for (int it = 0; it < NCYC; it++) begin
      @(posedge clk);
      model_step();
      #1;
      if (it == 2) resetb = 1'b1;
      if (it == NCYC / 2) begin
        // Asynchronous reset mid-run must take effect without a clock edge.
        resetb = 1'b0;
        #1;
        check1("async_rst_iso", {{(NCH*W-1){1'b0}}, iso_active}, {{(NCH*W-1){1'b0}}, 1'b1});
        check1("async_rst_ack", {{(NCH*W-1){1'b0}}, sleep_ack},  {{(NCH*W-1){1'b0}}, 1'b1});
        check1("async_rst_flt", {{(NCH*W-1){1'b0}}, pwr_fault},  {{(NCH*W-1){1'b0}}, 1'b0});
        model_reset();
      end
      if (it == NCYC / 2 + 2) resetb = 1'b1;
      randomize_inputs(it);
      exp_q.push_back(model_out());
      started = 1'b1;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scs8hd_lpflow_isoseq.md
# scs8hd_lpflow_isoseq

Parametrised, sequenced input-isolation controller for low-power domain boundaries. It generalises the single-bit AND-clamp isolator to N channels of W bits with a per-bit clamp pattern and per-channel exemption mask. It adds a registered isolate/release handshake with programmable settle delays and emergency isolation on power-good loss. It sits on the always-on side, between a switchable domain's outputs and always-on logic, under the power controller.

## Interface
- NCH, 4, number of channels
- W, 8, bits per channel
- CLAMP_VAL, {W{1'b0}}, W-bit value driven on each isolated channel
- ISO_DLY, 2, cycles from iso_active rise to sleep_ack rise (0..15)
- REL_DLY, 3, cycles from release start to iso_active fall (0..15)

- clk  input  1  clock, rising edge
- resetb  input  1  reset, asynchronous, active-low
- a  input  NCH*W  data from switchable domain; channel i = a[i*W +: W]
- x  output  NCH*W  isolated data to always-on logic
- chan_mask  input  NCH  1 = channel exempt (pass-through always); quasi-static
- sleep_req  input  1  power controller requests isolation
- pwrgood  input  1  switchable domain supply valid
- iso_active  output  1  isolation applied to non-exempt channels
- sleep_ack  output  1  isolation settled; domain may be powered down
- pwr_fault  output  1  sticky: pwrgood fell while ACTIVE

## Operation
- Data path combinational: x[i] = (iso_active & ~chan_mask[i]) ? CLAMP_VAL : a[i].
- FSM states: ACTIVE, ISO_WAIT, ISOLATED, REL_WAIT. All control outputs are registered.
- Reset: state ISOLATED; iso_active=1, sleep_ack=1, pwr_fault=0, counter=0. The block powers up isolated.
- ACTIVE, sleep_req=1: go to ISO_WAIT, iso_active=1, counter=ISO_DLY. If ISO_DLY=0, go directly to ISOLATED with sleep_ack=1 on the same edge.
- ISO_WAIT: decrement the counter each cycle. At 1, the next edge sets sleep_ack=1 and enters ISOLATED. Dropping sleep_req does not abort the sequence.
- ISOLATED, sleep_req=0 and pwrgood=1: go to REL_WAIT, sleep_ack=0, counter=REL_DLY. If REL_DLY=0, go directly to ACTIVE with iso_active=0.
- REL_WAIT: decrement the counter. At 1, the next edge sets iso_active=0 and enters ACTIVE.
- REL_WAIT abort: if sleep_req=1 or pwrgood=0, go back to ISOLATED and set sleep_ack=1 on the next edge. iso_active never dropped.
- ACTIVE with pwrgood=0 (emergency isolation): go to ISOLATED, iso_active=1, sleep_ack=1, pwr_fault=1 on the next edge. This takes priority over sleep_req.
- pwr_fault clears on entry to REL_WAIT or on reset.
- Counter width is 4 bits. Delay parameters outside 0..15 are an elaboration error.

## Timing
- Data path latency is 0 cycles. Control latency is 1 edge from the sampled input.
- Isolate: sleep_req seen at edge k gives iso_active=1 after k and sleep_ack=1 after k+ISO_DLY.
- Release: condition seen at edge k gives sleep_ack=0 after k and iso_active=0 after k+REL_DLY.
- sleep_ack=1 implies iso_active=1 in every cycle.
- resetb assertion mid-sequence forces the reset values immediately, without waiting for clk.

## Configuration
- LPFLOW_ISO_HOLD_EN defined: each channel has a W-bit hold register.
  - While iso_active=0, the hold register loads a every cycle.
  - While isolated, non-exempt channels drive the hold value instead of CLAMP_VAL.
  - Hold registers reset to CLAMP_VAL.
- LPFLOW_ISO_HOLD_EN undefined: no hold registers; isolated channels drive CLAMP_VAL.

## Test plan
- Reset release with sleep_req=0, pwrgood=1, NCH=4, W=8, CLAMP_VAL=8'h00, a=32'hA5A5_5A5A -> x=0 and sleep_ack drops after edge 1. iso_active drops 3 edges later, then x=32'hA5A5_5A5A.
- From ACTIVE, pulse sleep_req high at edge k -> iso_active=1 after k and x=0 immediately. sleep_ack=1 after k+2. Deasserting sleep_req at k+1 still reaches ISOLATED.
- chan_mask=4'b0010, isolated, a=32'h1122_3344 -> x=32'h0000_3300.
- In REL_WAIT after 1 cycle, raise sleep_req -> ISOLATED, sleep_ack=1 the next edge, and iso_active stays 1 throughout.
- In ACTIVE, drop pwrgood -> iso_active=1, sleep_ack=1, pwr_fault=1 one edge later. pwr_fault holds until the release sequence starts.
- With LPFLOW_ISO_HOLD_EN, a=32'hDEAD_BEEF at isolation, then a changes to 32'h0 -> x holds 32'hDEAD_BEEF until release completes.
